// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Multicycle control unit for the MIPS-lite datapath. Sequences
//               each instruction through fetch/decode/execute/memory/write-back
//               states, drives every datapath strobe and mux select, and
//               counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl #(
    parameter int ALU_OP_LENGTH = 3,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               opcode,
    input  logic [5:0]               funct,
    input  logic                     zero,
    output logic                     pc_we,
    output logic [1:0]               pc_src,
    output logic                     ir_we,
    output logic                     RegWrite,
    output logic                     Memwrite,
    output logic                     MemRead,
    output logic                     ALUsrc_mux,
    output logic                     RegDst,
    output logic                     Write_reg_mux,
    output logic                     extend_op,
    output logic [ALU_OP_LENGTH-1:0] alu_op,
    output logic                     instr_done,
    output logic                     illegal,
    output logic [CNT_W-1:0]         retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_WB_R      = 4'd3,
        S_EXEC_I    = 4'd4,
        S_WB_I      = 4'd5,
        S_EXEC_ADDR = 4'd6,
        S_MEM_RD    = 4'd7,
        S_WB_MEM    = 4'd8,
        S_MEM_WR    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [ALU_OP_LENGTH-1:0] c_ALU_ADDU = ALU_OP_LENGTH'(0);
    localparam logic [ALU_OP_LENGTH-1:0] c_ALU_SUBU = ALU_OP_LENGTH'(1);
    localparam logic [ALU_OP_LENGTH-1:0] c_ALU_AND  = ALU_OP_LENGTH'(2);
    localparam logic [ALU_OP_LENGTH-1:0] c_ALU_OR   = ALU_OP_LENGTH'(3);
    localparam logic [ALU_OP_LENGTH-1:0] c_ALU_SLT  = ALU_OP_LENGTH'(4);
    localparam logic [ALU_OP_LENGTH-1:0] c_ALU_LUI  = ALU_OP_LENGTH'(5);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    state_t                     r_state;
    state_t                     w_next;
    logic [CNT_W-1:0]           r_retired;
    logic                       w_r_legal;
    logic [ALU_OP_LENGTH-1:0]   w_r_alu;
    logic [ALU_OP_LENGTH-1:0]   w_i_alu;
    logic                       w_i_ext;

    // Decode R-type funct and I-type opcode into ALU operation / extend mode
    always_comb begin
        w_r_legal = 1'b1;
        w_r_alu   = c_ALU_ADDU;
        case (funct)
            6'h21:   w_r_alu = c_ALU_ADDU;
            6'h23:   w_r_alu = c_ALU_SUBU;
            6'h24:   w_r_alu = c_ALU_AND;
            6'h25:   w_r_alu = c_ALU_OR;
            6'h2A:   w_r_alu = c_ALU_SLT;
            default: w_r_legal = 1'b0;
        endcase
        w_i_alu = c_ALU_LUI;
        w_i_ext = 1'b0;
        case (opcode)
            c_OP_ADDIU: begin w_i_alu = c_ALU_ADDU; w_i_ext = 1'b1; end
            c_OP_ORI:   begin w_i_alu = c_ALU_OR;   w_i_ext = 1'b0; end
            default:    begin w_i_alu = c_ALU_LUI;  w_i_ext = 1'b0; end
        endcase
    end

    // Next-state and Moore output decode; reset forces every output low
    always_comb begin
        w_next        = r_state;
        pc_we         = 1'b0;
        pc_src        = 2'd0;
        ir_we         = 1'b0;
        RegWrite      = 1'b0;
        Memwrite      = 1'b0;
        MemRead       = 1'b0;
        ALUsrc_mux    = 1'b0;
        RegDst        = 1'b0;
        Write_reg_mux = 1'b0;
        extend_op     = 1'b0;
        alu_op        = c_ALU_ADDU;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_we  = 1'b1;
                pc_we  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    c_OP_RTYPE:                   w_next = w_r_legal ? S_EXEC_R : S_ILLEGAL;
                    c_OP_ADDIU, c_OP_ORI, c_OP_LUI: w_next = S_EXEC_I;
                    c_OP_LW, c_OP_SW:             w_next = S_EXEC_ADDR;
                    c_OP_BEQ:                     w_next = S_BRANCH;
                    c_OP_J:                       w_next = S_JUMP;
                    default:                      w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                alu_op = w_r_alu;
                w_next = S_WB_R;
            end
            S_WB_R: begin
                alu_op     = w_r_alu;
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXEC_I: begin
                ALUsrc_mux = 1'b1;
                extend_op  = w_i_ext;
                alu_op     = w_i_alu;
                w_next     = S_WB_I;
            end
            S_WB_I: begin
                ALUsrc_mux = 1'b1;
                extend_op  = w_i_ext;
                alu_op     = w_i_alu;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXEC_ADDR: begin
                ALUsrc_mux = 1'b1;
                extend_op  = 1'b1;
                w_next     = (opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ALUsrc_mux = 1'b1;
                extend_op  = 1'b1;
                MemRead    = 1'b1;
                w_next     = S_WB_MEM;
            end
            S_WB_MEM: begin
                ALUsrc_mux    = 1'b1;
                extend_op     = 1'b1;
                MemRead       = 1'b1;
                RegWrite      = 1'b1;
                Write_reg_mux = 1'b1;
                instr_done    = 1'b1;
                w_next        = S_FETCH;
            end
            S_MEM_WR: begin
                ALUsrc_mux = 1'b1;
                extend_op  = 1'b1;
                Memwrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_op     = c_ALU_SUBU;
                extend_op  = 1'b1;
                pc_src     = 2'd1;
                pc_we      = zero;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                pc_we      = 1'b1;
                pc_src     = 2'd2;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        if (rst) begin
            pc_we         = 1'b0;
            pc_src        = 2'd0;
            ir_we         = 1'b0;
            RegWrite      = 1'b0;
            Memwrite      = 1'b0;
            MemRead       = 1'b0;
            ALUsrc_mux    = 1'b0;
            RegDst        = 1'b0;
            Write_reg_mux = 1'b0;
            extend_op     = 1'b0;
            alu_op        = c_ALU_ADDU;
            instr_done    = 1'b0;
            illegal       = 1'b0;
        end
    end

    // State register and retired-instruction counter (wraps silently)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (instr_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign retired = rst ? '0 : r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mc_ctrl
// Description : Directed self-checking bench for mips_mc_ctrl. A narrow
//               retired counter is used so that wrap-around is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;

    localparam int c_CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic               ir_we;
    logic               RegWrite;
    logic               Memwrite;
    logic               MemRead;
    logic               ALUsrc_mux;
    logic               RegDst;
    logic               Write_reg_mux;
    logic               extend_op;
    logic [2:0]         alu_op;
    logic               instr_done;
    logic               illegal;
    logic [c_CNT_W-1:0] retired;

    int checks   = 0;
    int failures = 0;

    // {ir_we, pc_we, RegWrite, Memwrite, MemRead, instr_done, illegal}
    logic [6:0] strb;
    assign strb = {ir_we, pc_we, RegWrite, Memwrite, MemRead, instr_done, illegal};

    localparam logic [6:0] c_S_NONE   = 7'b0000000;
    localparam logic [6:0] c_S_FETCH  = 7'b1100000;
    localparam logic [6:0] c_S_WB     = 7'b0010010;
    localparam logic [6:0] c_S_MEMRD  = 7'b0000100;
    localparam logic [6:0] c_S_WBMEM  = 7'b0010110;
    localparam logic [6:0] c_S_MEMWR  = 7'b0001010;
    localparam logic [6:0] c_S_PCDONE = 7'b0100010;
    localparam logic [6:0] c_S_DONE   = 7'b0000010;
    localparam logic [6:0] c_S_ILL    = 7'b0000001;

    mips_mc_ctrl #(
        .ALU_OP_LENGTH(3),
        .CNT_W        (c_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .ir_we        (ir_we),
        .RegWrite     (RegWrite),
        .Memwrite     (Memwrite),
        .MemRead      (MemRead),
        .ALUsrc_mux   (ALUsrc_mux),
        .RegDst       (RegDst),
        .Write_reg_mux(Write_reg_mux),
        .extend_op    (extend_op),
        .alu_op       (alu_op),
        .instr_done   (instr_done),
        .illegal      (illegal),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Present the instruction fields and check the FETCH cycle
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic z, input string tag);
        opcode = op;
        funct  = fn;
        zero   = z;
        #1;
        chk({tag, "_fetch_strb"}, 32'(strb), 32'(c_S_FETCH));
        chk({tag, "_fetch_pcsrc"}, 32'(pc_src), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;

        // Reset: all outputs low, counter cleared
        nxt();
        chk("rst_strb", 32'(strb), 32'(c_S_NONE));
        chk("rst_retired", 32'(retired), 32'd0);
        nxt();
        chk("rst_strb2", 32'(strb), 32'(c_S_NONE));
        chk("rst_misc", 32'({pc_src, ALUsrc_mux, RegDst, Write_reg_mux, extend_op, alu_op}), 32'd0);
        rst = 1'b0;

        // addu
        fetch(6'h00, 6'h21, 1'b0, "addu");
        nxt(); chk("addu_dec", 32'(strb), 32'(c_S_NONE));
        nxt(); chk("addu_ex_strb", 32'(strb), 32'(c_S_NONE));
        chk("addu_ex_alu", 32'({ALUsrc_mux, alu_op}), 32'h0);
        nxt(); chk("addu_wb_strb", 32'(strb), 32'(c_S_WB));
        chk("addu_wb_sel", 32'({RegDst, Write_reg_mux, alu_op}), 32'b1_0_000);
        chk("addu_ret_before", 32'(retired), 32'd0);
        nxt(); chk("addu_ret", 32'(retired), 32'd1);

        // subu
        fetch(6'h00, 6'h23, 1'b0, "subu");
        nxt(); nxt(); chk("subu_ex_alu", 32'(alu_op), 32'd1);
        nxt(); chk("subu_wb_strb", 32'(strb), 32'(c_S_WB));
        nxt(); chk("subu_ret", 32'(retired), 32'd2);

        // slt
        fetch(6'h00, 6'h2A, 1'b0, "slt");
        nxt(); nxt(); chk("slt_ex_alu", 32'(alu_op), 32'd4);
        nxt(); nxt(); chk("slt_ret", 32'(retired), 32'd3);

        // addiu: sign-extend, ADDU, rt destination
        fetch(6'h09, 6'h00, 1'b0, "addiu");
        nxt(); nxt(); chk("addiu_ex", 32'({ALUsrc_mux, extend_op, alu_op}), 32'b1_1_000);
        nxt(); chk("addiu_wb_strb", 32'(strb), 32'(c_S_WB));
        chk("addiu_wb_sel", 32'({RegDst, Write_reg_mux}), 32'b00);
        nxt(); chk("addiu_ret", 32'(retired), 32'd4);

        // ori: zero-extend, OR
        fetch(6'h0D, 6'h00, 1'b0, "ori");
        nxt(); nxt(); chk("ori_ex", 32'({ALUsrc_mux, extend_op, alu_op}), 32'b1_0_011);
        nxt(); nxt();

        // lui
        fetch(6'h0F, 6'h00, 1'b0, "lui");
        nxt(); nxt(); chk("lui_ex_alu", 32'(alu_op), 32'd5);
        nxt(); nxt(); chk("lui_ret", 32'(retired), 32'd6);

        // lw: five cycles, MemRead in 4-5, RegWrite with memory data in 5
        fetch(6'h23, 6'h00, 1'b0, "lw");
        nxt(); chk("lw_dec", 32'(strb), 32'(c_S_NONE));
        nxt(); chk("lw_addr", 32'({strb, ALUsrc_mux, extend_op, alu_op}), {20'd0, c_S_NONE, 5'b11_000});
        nxt(); chk("lw_memrd", 32'(strb), 32'(c_S_MEMRD));
        nxt(); chk("lw_wbmem", 32'(strb), 32'(c_S_WBMEM));
        chk("lw_wb_sel", 32'({RegDst, Write_reg_mux}), 32'b01);
        nxt(); chk("lw_ret", 32'(retired), 32'd7);

        // sw: Memwrite only in cycle 4
        fetch(6'h2B, 6'h00, 1'b0, "sw");
        nxt(); nxt(); chk("sw_addr", 32'(strb), 32'(c_S_NONE));
        nxt(); chk("sw_memwr", 32'(strb), 32'(c_S_MEMWR));
        nxt(); chk("sw_next_fetch", 32'(strb), 32'(c_S_FETCH));
        chk("sw_ret", 32'(retired), 32'd8);

        // beq taken
        fetch(6'h04, 6'h00, 1'b1, "beqt");
        nxt(); nxt(); chk("beqt_strb", 32'(strb), 32'(c_S_PCDONE));
        chk("beqt_ctl", 32'({pc_src, extend_op, ALUsrc_mux, alu_op}), 32'b01_1_0_001);
        nxt(); chk("beqt_ret", 32'(retired), 32'd9);

        // beq not taken
        fetch(6'h04, 6'h00, 1'b0, "beqn");
        nxt(); nxt(); chk("beqn_strb", 32'(strb), 32'(c_S_DONE));
        chk("beqn_pcsrc", 32'(pc_src), 32'd1);
        nxt(); chk("beqn_ret", 32'(retired), 32'd10);

        // j
        fetch(6'h02, 6'h00, 1'b0, "j");
        nxt(); nxt(); chk("j_strb", 32'(strb), 32'(c_S_PCDONE));
        chk("j_pcsrc", 32'(pc_src), 32'd2);
        nxt(); chk("j_ret", 32'(retired), 32'd11);

        // undefined opcode
        fetch(6'h3F, 6'h00, 1'b0, "ill");
        nxt(); nxt(); chk("ill_strb", 32'(strb), 32'(c_S_ILL));
        nxt(); chk("ill_next_fetch", 32'(strb), 32'(c_S_FETCH));
        chk("ill_ret", 32'(retired), 32'd11);

        // R-type with unknown funct
        fetch(6'h00, 6'h00, 1'b0, "illr");
        nxt(); nxt(); chk("illr_strb", 32'(strb), 32'(c_S_ILL));
        nxt(); chk("illr_ret", 32'(retired), 32'd11);

        // lw abandoned by reset in MEM_RD
        fetch(6'h23, 6'h00, 1'b0, "lwrst");
        nxt(); nxt(); nxt();
        chk("lwrst_memrd", 32'(strb), 32'(c_S_MEMRD));
        rst = 1'b1;
        #1;
        chk("lwrst_in_rst", 32'(strb), 32'(c_S_NONE));
        nxt(); chk("lwrst_after_edge", 32'(strb), 32'(c_S_NONE));
        chk("lwrst_ret", 32'(retired), 32'd0);
        rst = 1'b0;

        // Wrap: 15 jumps bring a 4-bit counter to all-ones, one more wraps it
        for (int i = 0; i < 15; i++) begin
            fetch(6'h02, 6'h00, 1'b0, "wrapj");
            nxt(); nxt(); chk("wrapj_strb", 32'(strb), 32'(c_S_PCDONE));
            nxt();
        end
        chk("wrap_allones", 32'(retired), 32'hF);
        fetch(6'h00, 6'h25, 1'b0, "or");
        nxt(); nxt(); chk("or_ex_alu", 32'(alu_op), 32'd3);
        nxt(); nxt(); chk("wrap_zero", 32'(retired), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle control unit for the MIPS-lite datapath.
- Consumes the opcode, funct and ALU zero flag coming back from the datapath.
- Drives every datapath strobe and mux select: PC/IR write, register-file write, memory write/read, ALU source, register destination, write-back source, extend op, ALU op.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and counts retired instructions.

Parameters:
- ALU_OP_LENGTH, 3, width of alu_op. Encodings: 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLT, 5 LUI.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from IR.
- funct  in  6  instruction[5:0] from IR.
- zero  in  1  ALU result == 0.
- pc_we  out  1  PC register write enable.
- pc_src  out  2  next-PC select: 0 = pc+4, 1 = branch target, 2 = jump target.
- ir_we  out  1  IR write enable.
- RegWrite  out  1  register-file write enable.
- Memwrite  out  1  data-memory write enable.
- MemRead  out  1  data-memory read strobe.
- ALUsrc_mux  out  1  0 = RD2, 1 = extended immediate.
- RegDst  out  1  0 = rt, 1 = rd.
- Write_reg_mux  out  1  0 = ALU result, 1 = memory data.
- extend_op  out  1  0 = zero-extend, 1 = sign-extend.
- alu_op  out  ALU_OP_LENGTH  ALU operation.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  one-cycle pulse when an unsupported opcode/funct is decoded.
- retired  out  CNT_W  count of completed legal instructions.

Behaviour:
- Reset:
  - While rst = 1: state <= FETCH, retired <= 0, and every output is forced to 0, including ir_we and pc_we.
  - The first cycle after rst falls is FETCH.
  - rst asserted mid-instruction abandons the instruction. No write strobe may assert in the reset cycle or after it until the next FETCH.
- Outputs:
  - Moore outputs, decoded combinationally from state plus the opcode/funct inputs.
  - opcode/funct are stable from DECODE onward because IR is written only in FETCH.
- Supported instructions:
  - R-type (opcode 0x00): addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A.
  - I-type: addiu 0x09 (sign-extend, ADDU), ori 0x0D (zero-extend, OR), lui 0x0F (LUI).
  - Memory and control flow: lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- FETCH:
  - ir_we = 1, pc_we = 1, pc_src = 0.
  - Next state: DECODE.
- DECODE:
  - No strobes asserted.
  - Next state by opcode:
    - R-type -> EXEC_R; unrecognised funct -> ILLEGAL.
    - addiu/ori/lui -> EXEC_I.
    - lw/sw -> EXEC_ADDR.
    - beq -> BRANCH.
    - j -> JUMP.
    - anything else -> ILLEGAL.
- EXEC_R:
  - ALUsrc_mux = 0, alu_op from funct.
  - Next state: WB_R.
- WB_R:
  - RegWrite = 1, RegDst = 1, Write_reg_mux = 0, ALU controls held from EXEC_R.
  - instr_done = 1.
  - Next state: FETCH.
- EXEC_I:
  - ALUsrc_mux = 1, extend_op and alu_op per opcode.
  - Next state: WB_I.
- WB_I:
  - RegWrite = 1, RegDst = 0, Write_reg_mux = 0, ALU controls held.
  - instr_done = 1.
  - Next state: FETCH.
- EXEC_ADDR:
  - ALUsrc_mux = 1, extend_op = 1, alu_op = ADDU.
  - Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD:
  - Address controls held, MemRead = 1.
  - Next state: WB_MEM.
- WB_MEM:
  - Address controls held, MemRead = 1, RegWrite = 1, RegDst = 0, Write_reg_mux = 1.
  - instr_done = 1.
  - Next state: FETCH.
- MEM_WR:
  - Address controls held, Memwrite = 1 for exactly one cycle.
  - instr_done = 1.
  - Next state: FETCH.
- BRANCH:
  - ALUsrc_mux = 0, alu_op = SUBU, extend_op = 1, pc_src = 1, pc_we = zero.
  - instr_done = 1.
  - Next state: FETCH.
- JUMP:
  - pc_we = 1, pc_src = 2.
  - instr_done = 1.
  - Next state: FETCH.
- ILLEGAL:
  - illegal = 1, no write strobes.
  - Next state: FETCH. Treated as a no-op; retired is not incremented.
- Latency in cycles, including FETCH:
  - R-type 4, I-type 4, lw 5, sw 4, beq 3, j 3, illegal 3.
- Invariants:
  - At most one of RegWrite/Memwrite is asserted in any cycle.
  - ir_we is asserted only in FETCH.
- retired:
  - Increments by 1 on every instr_done cycle.
  - Wraps from all-ones to 0 with no flag.

Test Plan:
- Reset then release, opcode = 0 -> during reset all outputs 0. Cycle 1: ir_we = pc_we = 1, pc_src = 0. Cycle 2: all strobes 0.
- addu (opcode 0x00, funct 0x21) -> alu_op = 0, RegDst = 1, RegWrite = 1 only in cycle 4; instr_done in cycle 4; retired goes 0 -> 1.
- lw (0x23) then sw (0x2B) -> lw: MemRead in cycles 4-5, RegWrite with Write_reg_mux = 1 in cycle 5. sw: Memwrite = 1 only in cycle 4, RegWrite never set.
- beq (0x04) with zero = 1 then zero = 0 -> pc_we = 1, pc_src = 1 in cycle 3; then pc_we = 0 in cycle 3. Both pulse instr_done.
- j (0x02) and undefined opcode 0x3F -> j: pc_we = 1, pc_src = 2 in cycle 3. 0x3F: illegal pulse in cycle 3, no strobes, retired unchanged.
- rst asserted in MEM_RD of lw; separately, retired preset to all-ones -> reset case: no RegWrite, FETCH follows deassert. Preset case: next completion yields retired = 0.
